// File: rtl/guess_game_ctrl.sv
// Number-guessing game sequencer: draws BCD answers from a free-running LFSR,
// takes guesses on confirm presses, drives the higher/lower hint and tracks
// rounds won and wrong guesses until WIN or LOSE.
module guess_game_ctrl #(
  parameter int unsigned MAX_ROUNDS = 5,
  parameter int unsigned MAX_MISSES = 7,
  parameter logic [11:0] LFSR_SEED  = 12'hA5C
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       confirm_btn,
  input  logic [1:0] max_digit,
  input  logic [3:0] key0,
  input  logic [3:0] key1,
  input  logic [3:0] key2,
  output logic [3:0] answer0,
  output logic [3:0] answer1,
  output logic [3:0] answer2,
  output logic [1:0] hint,
  output logic [2:0] round,
  output logic [2:0] misses,
  output logic [2:0] state,
  output logic       win,
  output logic       lose
);

  localparam int unsigned DW = 4;        // bits per BCD digit
  localparam int unsigned VW = 3 * DW;   // three-digit value width
  localparam int unsigned LW = 12;       // LFSR width
  localparam int unsigned CW = 3;        // counter width

  localparam logic [1:0] HINT_LOWER  = 2'b00;
  localparam logic [1:0] HINT_HIGHER = 2'b01;
  localparam logic [1:0] HINT_BLANK  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_GUESS = 3'd2,
    S_CHECK = 3'd3,
    S_WIN   = 3'd4,
    S_LOSE  = 3'd5
  } state_e;

  state_e          state_q;
  logic            confirm_q;
  logic [LW-1:0]   lfsr_q;
  logic [VW-1:0]   answer_q;
  logic [1:0]      hint_q;
  logic [CW-1:0]   round_q;
  logic [CW-1:0]   misses_q;
  logic            win_q;
  logic            lose_q;

  logic            press_c;
  logic [1:0]      nd_c;
  logic [VW-1:0]   mask_c;
  logic [LW-1:0]   lfsr_d;
  logic [VW-1:0]   load_c;
  logic [VW-1:0]   guess_c;
  logic [VW-1:0]   ans_c;
  logic [CW-1:0]   round_d;
  logic [CW-1:0]   misses_d;

  // Fold a raw LFSR nibble into the BCD range 0..9.
  function automatic logic [DW-1:0] to_bcd(input logic [DW-1:0] n);
    return (n > 4'd9) ? (n - 4'd6) : n;
  endfunction

  // Rising-edge press detect, digit-count mask, LFSR step and compare operands.
  always_comb begin
    press_c  = confirm_btn & ~confirm_q;
    nd_c     = (max_digit == 2'd0) ? 2'd1 : max_digit;
    mask_c   = 12'hFFF;
    case (nd_c)
      2'd1:    mask_c = 12'h00F;
      2'd2:    mask_c = 12'h0FF;
      default: mask_c = 12'hFFF;
    endcase
    lfsr_d   = {lfsr_q[LW-2:0], lfsr_q[11] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0]};
    load_c   = {to_bcd(lfsr_q[11:8]), to_bcd(lfsr_q[7:4]), to_bcd(lfsr_q[3:0])} & mask_c;
    // Unsigned compare of the packed digits equals an MSD-first digit compare.
    guess_c  = {key2, key1, key0} & mask_c;
    ans_c    = answer_q & mask_c;
    round_d  = round_q + CW'(1);
    misses_d = misses_q + CW'(1);
  end

  // Game sequencer with registered outputs; leaving CHECK at the limit keeps counters from wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      confirm_q <= 1'b1;
      lfsr_q    <= LFSR_SEED;
      answer_q  <= '0;
      hint_q    <= HINT_BLANK;
      round_q   <= '0;
      misses_q  <= '0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
    end else begin
      confirm_q <= confirm_btn;
      lfsr_q    <= lfsr_d;
      case (state_q)
        S_IDLE: begin
          round_q  <= '0;
          misses_q <= '0;
          hint_q   <= HINT_BLANK;
          win_q    <= 1'b0;
          lose_q   <= 1'b0;
          if (press_c) state_q <= S_LOAD;
        end
        S_LOAD: begin
          answer_q <= load_c;
          state_q  <= S_GUESS;
        end
        S_GUESS: begin
          if (press_c) state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (guess_c == ans_c) begin
            hint_q  <= HINT_BLANK;
            round_q <= round_d;
            if (round_d == CW'(MAX_ROUNDS)) begin
              state_q <= S_WIN;
              win_q   <= 1'b1;
            end else begin
              state_q <= S_LOAD;
            end
          end else begin
            hint_q   <= (guess_c > ans_c) ? HINT_LOWER : HINT_HIGHER;
            misses_q <= misses_d;
            if (misses_d == CW'(MAX_MISSES)) begin
              state_q <= S_LOSE;
              lose_q  <= 1'b1;
            end else begin
              state_q <= S_GUESS;
            end
          end
        end
        S_WIN, S_LOSE: begin
          hint_q <= HINT_BLANK;
          if (press_c) begin
            state_q  <= S_IDLE;
            round_q  <= '0;
            misses_q <= '0;
            win_q    <= 1'b0;
            lose_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign answer0 = answer_q[3:0];
  assign answer1 = answer_q[7:4];
  assign answer2 = answer_q[11:8];
  assign hint    = hint_q;
  assign round   = round_q;
  assign misses  = misses_q;
  assign state   = 3'(state_q);
  assign win     = win_q;
  assign lose    = lose_q;

endmodule
